// File: rtl/id_gen.sv
// Identifier generator: emits <letters>+<digits>+<terminator> as a registered byte stream.
// Latency: first char valid one cycle after an accepted start; one char per transfer after that.
// Backpressure: ready=0 while valid=1 freezes char, valid, state and all counters.
//
// Ports:
//   clk        posedge clock for all logic
//   reset      synchronous, active-high; has priority over start
//   start      request a new identifier; only sampled while idle
//   alpha_len  letter count, latched on an accepted start (must be nonzero)
//   digit_len  digit count, latched on an accepted start (must be nonzero)
//   upper      1: letters start at "A", 0: letters start at "a"; latched on start
//   ready      sink accepts char this cycle when valid=1
//   char       current ASCII byte (registered)
//   valid      char is meaningful
//   busy       generator is not idle
//   done       one-cycle pulse after the terminator has been accepted
//   err        one-cycle pulse when start arrives with a zero length field
module id_gen #(
  parameter int         CNT_W     = 5,
  parameter logic [7:0] TERM_CHAR = 8'h20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] alpha_len,
  input  logic [CNT_W-1:0] digit_len,
  input  logic             upper,
  input  logic             ready,
  output logic [7:0]       char,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALPHA = 2'd1,
    DIGIT = 2'd2,
    TERM  = 2'd3
  } state_t;

  localparam logic [7:0] LOWER_A = 8'h61;
  localparam logic [7:0] UPPER_A = 8'h41;
  localparam logic [7:0] ZERO_CH = 8'h30;

  state_t           state_q, state_d;
  logic [7:0]       char_q, char_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] alpha_len_q, alpha_len_d;
  logic [CNT_W-1:0] digit_len_q, digit_len_d;
  logic             upper_q, upper_d;
  // Position within the current run (letters or digits); compared against the latched length.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Wrapping offsets into the alphabet (0..25) and digit set (0..9), kept separately
  // from cnt so no modulo hardware is needed.
  logic [4:0]       lidx_q, lidx_d;
  logic [3:0]       didx_q, didx_d;

  logic             xfer;
  logic [4:0]       lidx_nxt;
  logic [3:0]       didx_nxt;
  logic [7:0]       letter_base;

  assign xfer        = valid_q & ready;
  assign lidx_nxt    = (lidx_q == 5'd25) ? 5'd0 : lidx_q + 5'd1;
  assign didx_nxt    = (didx_q == 4'd9) ? 4'd0 : didx_q + 4'd1;
  assign letter_base = upper_q ? UPPER_A : LOWER_A;

  always_comb begin
    state_d     = state_q;
    char_d      = char_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    alpha_len_d = alpha_len_q;
    digit_len_d = digit_len_q;
    upper_d     = upper_q;
    cnt_d       = cnt_q;
    lidx_d      = lidx_q;
    didx_d      = didx_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if ((alpha_len != '0) && (digit_len != '0)) begin
            state_d     = ALPHA;
            alpha_len_d = alpha_len;
            digit_len_d = digit_len;
            upper_d     = upper;
            cnt_d       = '0;
            lidx_d      = 5'd0;
            didx_d      = 4'd0;
            // First letter is presented straight away; the input upper is used because
            // upper_q only picks up the new value at this edge.
            char_d      = upper ? UPPER_A : LOWER_A;
            valid_d     = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ALPHA: begin
        if (xfer) begin
          if (cnt_q == alpha_len_q - CNT_W'(1)) begin
            state_d = DIGIT;
            cnt_d   = '0;
            didx_d  = 4'd0;
            char_d  = ZERO_CH;
          end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            lidx_d = lidx_nxt;
            char_d = letter_base + {3'b000, lidx_nxt};
          end
        end
      end

      DIGIT: begin
        if (xfer) begin
          if (cnt_q == digit_len_q - CNT_W'(1)) begin
            state_d = TERM;
            cnt_d   = '0;
            char_d  = TERM_CHAR;
          end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            didx_d = didx_nxt;
            char_d = ZERO_CH + {4'b0000, didx_nxt};
          end
        end
      end

      TERM: begin
        if (xfer) begin
          state_d = IDLE;
          valid_d = 1'b0;
          char_d  = 8'h00;
          cnt_d   = '0;
          lidx_d  = 5'd0;
          didx_d  = 4'd0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        char_d  = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      char_q      <= 8'h00;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      alpha_len_q <= '0;
      digit_len_q <= '0;
      upper_q     <= 1'b0;
      cnt_q       <= '0;
      lidx_q      <= 5'd0;
      didx_q      <= 4'd0;
    end else begin
      state_q     <= state_d;
      char_q      <= char_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      alpha_len_q <= alpha_len_d;
      digit_len_q <= digit_len_d;
      upper_q     <= upper_d;
      cnt_q       <= cnt_d;
      lidx_q      <= lidx_d;
      didx_q      <= didx_d;
    end
  end

  assign char  = char_q;
  assign valid = valid_q;
  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_id_gen.sv
// Randomized bench for id_gen: expected char stream is built per request as a queue
// and popped on every accepted transfer, with random ready stalls and stray starts.
module tb_id_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [4:0] alpha_len;
  logic [4:0] digit_len;
  logic       upper;
  logic       ready;
  logic [7:0] char;
  logic       valid;
  logic       busy;
  logic       done;
  logic       err;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  id_gen #(.CNT_W(5), .TERM_CHAR(8'h20)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .alpha_len (alpha_len),
    .digit_len (digit_len),
    .upper     (upper),
    .ready     (ready),
    .char      (char),
    .valid     (valid),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_idle(input string tag, input logic exp_done, input logic exp_err);
    check_val({tag, "_char"},  {24'h0, char}, 32'h0);
    check_val({tag, "_valid"}, {31'h0, valid}, 32'h0);
    check_val({tag, "_busy"},  {31'h0, busy}, 32'h0);
    check_val({tag, "_done"},  {31'h0, done}, {31'h0, exp_done});
    check_val({tag, "_err"},   {31'h0, err}, {31'h0, exp_err});
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the done pulse.
  task automatic run_id(input int alen, input int dlen, input bit up, input int rdy_pct);
    logic [7:0] exp_q[$];
    int         cyc;
    bit         rdy;
    for (int k = 0; k < alen; k++) exp_q.push_back(8'((up ? 65 : 97) + (k % 26)));
    for (int k = 0; k < dlen; k++) exp_q.push_back(8'(48 + (k % 10)));
    exp_q.push_back(8'h20);

    start     = 1'b1;
    alpha_len = 5'(alen);
    digit_len = 5'(dlen);
    upper     = up;
    ready     = 1'($urandom_range(1));
    @(negedge clk);
    start     = 1'b0;
    // Post-start changes must not disturb the latched request.
    alpha_len = 5'($urandom);
    digit_len = 5'($urandom);
    upper     = 1'($urandom_range(1));
    cyc       = 0;
    while (exp_q.size() > 0) begin
      check_val("valid", {31'h0, valid}, 32'h1);
      check_val("char",  {24'h0, char}, {24'h0, exp_q[0]});
      check_val("busy",  {31'h0, busy}, 32'h1);
      check_val("done_mid", {31'h0, done}, 32'h0);
      check_val("err_mid",  {31'h0, err}, 32'h0);
      rdy   = ($urandom_range(99) < rdy_pct);
      ready = rdy;
      start = 1'($urandom_range(1));
      @(negedge clk);
      if (rdy) void'(exp_q.pop_front());
      cyc++;
      if (cyc > 2000) begin
        check_val("timeout", 32'h1, 32'h0);
        break;
      end
    end
    start = 1'b0;
    ready = 1'($urandom_range(1));
    if (rdy_pct >= 100) check_val("n_valid_cycles", cyc, alen + dlen + 1);
    check_idle("end", 1'b1, 1'b0);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    alpha_len = 5'd0;
    digit_len = 5'd0;
    upper     = 1'b0;
    ready     = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset", 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check_idle("post_reset", 1'b0, 1'b0);

    // Zero-length requests: err pulse, stay idle.
    start = 1'b1; alpha_len = 5'd3; digit_len = 5'd0;
    @(negedge clk);
    start = 1'b0;
    check_idle("err_dlen0", 1'b0, 1'b1);
    @(negedge clk);
    check_idle("err_clear", 1'b0, 1'b0);
    start = 1'b1; alpha_len = 5'd0; digit_len = 5'd4;
    @(negedge clk);
    start = 1'b0;
    check_idle("err_alen0", 1'b0, 1'b1);
    @(negedge clk);

    run_id(2, 3, 1'b0, 100);    // basic, back-to-back
    run_id(28, 12, 1'b1, 100);  // letter and digit wrap; started in the done cycle
    run_id(2, 3, 1'b0, 40);     // stalls
    run_id(31, 31, 1'b0, 70);   // maximum lengths
    run_id(1, 1, 1'b1, 100);    // minimum lengths
    for (int i = 0; i < 20; i++)
      run_id($urandom_range(31, 1), $urandom_range(31, 1), 1'($urandom_range(1)),
             $urandom_range(100, 20));

    // Reset mid-stream while char="b"; reset beats a simultaneous start.
    @(negedge clk);
    start = 1'b1; alpha_len = 5'd2; digit_len = 5'd3; upper = 1'b0; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("rst_a", {24'h0, char}, 32'h61);
    @(negedge clk);
    check_val("rst_b", {24'h0, char}, 32'h62);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check_idle("mid_reset", 1'b0, 1'b0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_idle("after_reset", 1'b0, 1'b0);
    run_id(2, 3, 1'b0, 100);
    @(negedge clk);
    check_idle("final", 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
